// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the fetch PC unit
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEF  = 4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

endpackage

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - modulo-2^32 sequential PC incrementer
module pc_incr #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);

    assign pc_next = pc + 32'(PC_STEP);

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF-stage PC sequencer with single-outstanding imem fetch and IF/ID register
module fetch_pc_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic        ImemValid,
    input  logic [31:0] ImemData,
    output logic [31:0] IfIdPC,
    output logic [31:0] IfIdPCAdd,
    output logic [31:0] IfIdInstr,
    output logic        IfIdValid
);

    fetch_state_e state_q, state_d;
    logic         drop_q, drop_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_pcadd_q, ifid_pcadd_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic         ifid_valid_q, ifid_valid_d;

    logic [31:0]  pc_plus;
    logic         accept;
    logic         deliver;
    logic [31:0]  deliver_word;

    pc_incr #(.PC_STEP(PC_STEP)) u_pc_incr (
        .pc      (pc_q),
        .pc_next (pc_plus)
    );

    assign ImemReq   = Reset && (state_q == S_REQ);
    assign ImemAddr  = pc_q;
    assign accept    = ImemReq && ImemReady;
    assign IfIdPC    = ifid_pc_q;
    assign IfIdPCAdd = ifid_pcadd_q;
    assign IfIdInstr = ifid_instr_q;
    assign IfIdValid = ifid_valid_q;

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        deliver      = 1'b0;
        deliver_word = ImemData;

        if (BranchTaken) begin
            // Redirect wins over stall; an old-path fetch still in flight gets marked for discard.
            pc_d   = BranchTarget & ~32'h3;
            hold_d = NOP_INSTR;
            unique case (state_q)
                S_REQ: begin
                    if (accept) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ImemValid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (accept) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (ImemValid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (!Stall) begin
                            deliver = 1'b1;
                            state_d = S_REQ;
                        end else begin
                            hold_d  = ImemData;
                            state_d = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (!Stall) begin
                        deliver      = 1'b1;
                        deliver_word = hold_q;
                        state_d      = S_REQ;
                    end
                end
            endcase
            if (deliver) pc_d = pc_plus;
        end
    end

    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_pcadd_d = ifid_pcadd_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = Stall ? ifid_valid_q : 1'b0;
        if (BranchTaken) begin
            ifid_valid_d = 1'b0;
        end else if (deliver) begin
            ifid_pc_d    = pc_q;
            ifid_pcadd_d = pc_plus;
            ifid_instr_d = deliver_word;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_REQ;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q   <= RESET_PC;
            hold_q <= NOP_INSTR;
        end else begin
            pc_q   <= pc_d;
            hold_q <= hold_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ifid_pc_q    <= '0;
            ifid_pcadd_q <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_pc_q    <= ifid_pc_d;
            ifid_pcadd_q <= ifid_pcadd_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - randomized and directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady = 1'b0;
    logic        ImemValid = 1'b0;
    logic [31:0] ImemData = '0;
    logic [31:0] IfIdPC;
    logic [31:0] IfIdPCAdd;
    logic [31:0] IfIdInstr;
    logic        IfIdValid;

    fetch_pc_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemReady    (ImemReady),
        .ImemValid    (ImemValid),
        .ImemData     (ImemData),
        .IfIdPC       (IfIdPC),
        .IfIdPCAdd    (IfIdPCAdd),
        .IfIdInstr    (IfIdInstr),
        .IfIdValid    (IfIdValid)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_i = 1'b0;
    logic [31:0] tgt_i = '0;
    logic        ready_i = 1'b1;
    int          lat_i = 0;
    logic        stray_i = 1'b0;

    logic        slot = 1'b0;
    int          slot_cnt = 0;
    logic [31:0] slot_addr = '0;

    logic [31:0] m_pc = '0;
    logic        m_inflight = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_held = 1'b0;
    logic [31:0] m_held_word = '0;
    logic [31:0] m_ifid_pc = '0;
    logic [31:0] m_ifid_add = '0;
    logic [31:0] m_ifid_instr = '0;
    logic        m_ifid_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic        exp_req;
        logic        acc;
        logic        vin;
        logic        dlv;
        logic [31:0] w;
        Reset        = rst_n;
        Stall        = stall_i;
        BranchTaken  = br_i;
        BranchTarget = tgt_i;
        ImemValid    = slot ? (slot_cnt == 0) : stray_i;
        ImemData     = slot ? mem_word(slot_addr) : $urandom();
        ImemReady    = ready_i && !slot;
        #1;
        exp_req = rst_n && !m_inflight && !m_held;
        chk("imem_req", ImemReq, exp_req);
        if (exp_req) chk("imem_addr", ImemAddr, m_pc);

        if (!rst_n) begin
            m_pc = 32'h0; m_inflight = 0; m_stale = 0; m_held = 0;
            m_ifid_pc = 0; m_ifid_add = 0; m_ifid_instr = 0; m_ifid_valid = 0;
        end else begin
            acc = exp_req && ImemReady;
            vin = ImemValid && m_inflight;
            dlv = 1'b0;
            w   = '0;
            if (br_i) begin
                if (acc) begin
                    m_inflight = 1; m_stale = 1;
                end else if (m_inflight) begin
                    if (vin) begin m_inflight = 0; m_stale = 0; end
                    else m_stale = 1;
                end
                m_held = 0;
                m_ifid_valid = 0;
                m_pc = tgt_i & ~32'h3;
            end else begin
                if (acc) begin
                    m_inflight = 1;
                end else if (vin) begin
                    m_inflight = 0;
                    if (m_stale) m_stale = 0;
                    else if (!stall_i) begin dlv = 1; w = ImemData; end
                    else begin m_held = 1; m_held_word = ImemData; end
                end else if (m_held && !stall_i) begin
                    dlv = 1; w = m_held_word; m_held = 0;
                end
                if (dlv) begin
                    m_ifid_pc = m_pc; m_ifid_add = m_pc + 32'd4;
                    m_ifid_instr = w; m_ifid_valid = 1; m_pc = m_pc + 32'd4;
                end else if (!stall_i) begin
                    m_ifid_valid = 0;
                end
            end
        end

        if (slot && slot_cnt == 0) slot = 1'b0;
        else if (slot) slot_cnt--;
        if (ImemReq && ImemReady) begin
            slot = 1'b1; slot_cnt = lat_i; slot_addr = ImemAddr;
        end

        @(posedge Clk);
        #1;
        chk("ifid_valid", IfIdValid, m_ifid_valid);
        chk("ifid_pc", IfIdPC, m_ifid_pc);
        chk("ifid_pcadd", IfIdPCAdd, m_ifid_add);
        chk("ifid_instr", IfIdInstr, m_ifid_instr);
    endtask

    task automatic wait_req(input int max_cycles);
        logic found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (ImemReq) begin found = 1'b1; break; end
            cycle();
        end
        if (!found && ImemReq) found = 1'b1;
        chk("wait_req_timeout", found, 1'b1);
    endtask

    initial begin
        logic [31:0] s_pc, s_instr;
        logic        exp_v [6];
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // T1 reset and sequential fetch
        rst_n = 0; ready_i = 1; lat_i = 0;
        cycle(); cycle();
        chk("rst_req", ImemReq, 1'b0);
        chk("rst_valid", IfIdValid, 1'b0);
        chk("rst_pc", IfIdPC, 32'h0);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t1_valid_pattern", IfIdValid, exp_v[i]);
            if (exp_v[i]) begin
                chk("t1_pc", IfIdPC, 32'(i / 2) * 32'd4);
                chk("t1_pcadd", IfIdPCAdd, 32'(i / 2) * 32'd4 + 32'd4);
                chk("t1_instr", IfIdInstr, 32'hA5A5_0000 ^ (32'(i / 2) * 32'd4));
            end
        end

        // T2 redirect while waiting
        lat_i = 2;
        cycle();
        br_i = 1; tgt_i = 32'h40;
        cycle();
        br_i = 0;
        chk("t2_valid_after_br", IfIdValid, 1'b0);
        cycle(); cycle();
        chk("t2_dropped", IfIdValid, 1'b0);
        wait_req(4);
        chk("t2_addr", ImemAddr, 32'h40);
        lat_i = 0;
        cycle(); cycle();
        chk("t2_pc", IfIdPC, 32'h40);
        chk("t2_valid", IfIdValid, 1'b1);

        // T3 redirect at acceptance
        br_i = 1; tgt_i = 32'h103;
        cycle();
        br_i = 0;
        cycle();
        chk("t3_dropped", IfIdValid, 1'b0);
        wait_req(4);
        chk("t3_addr", ImemAddr, 32'h100);
        cycle(); cycle();
        chk("t3_pc", IfIdPC, 32'h100);
        chk("t3_instr", IfIdInstr, 32'hA5A5_0100);

        // T4 stall across the response
        lat_i = 1;
        cycle();
        s_pc = IfIdPC; s_instr = IfIdInstr;
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_hold_pc", IfIdPC, s_pc);
            chk("t4_hold_instr", IfIdInstr, s_instr);
            chk("t4_no_req", ImemReq, 1'b0);
        end
        stall_i = 0;
        cycle();
        chk("t4_pc", IfIdPC, 32'h104);
        chk("t4_instr", IfIdInstr, 32'hA5A5_0104);
        chk("t4_valid", IfIdValid, 1'b1);

        // T5 wrap-around
        lat_i = 0; ready_i = 0; br_i = 1; tgt_i = 32'hFFFF_FFFE;
        cycle();
        br_i = 0; ready_i = 1;
        cycle(); cycle();
        chk("t5_pc", IfIdPC, 32'hFFFF_FFFC);
        chk("t5_pcadd", IfIdPCAdd, 32'h0);
        wait_req(3);
        chk("t5_addr", ImemAddr, 32'h0);

        // T6 reset with a response in flight
        lat_i = 2;
        cycle();
        rst_n = 0;
        cycle();
        rst_n = 1; lat_i = 0;
        chk("t6_valid", IfIdValid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_stale_ignored", IfIdValid, 1'b0);
        end
        chk("t6_addr", ImemAddr, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            stall_i = ($urandom_range(0, 2) == 0);
            br_i    = ($urandom_range(0, 7) == 0);
            tgt_i   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : ($urandom() & 32'h0000_FFFF);
            ready_i = ($urandom_range(0, 9) < 7);
            lat_i   = $urandom_range(0, 3);
            stray_i = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
